// File: rtl/cl_sde_sched_pkg.sv
// Shared types and register map for the SDE image scheduler.
// No logic; states, CSR offsets, STATUS bit positions and the unmapped-read value.
package cl_sde_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } sched_state_e;

    localparam logic [7:0] REG_CTRL         = 8'h00;
    localparam logic [7:0] REG_IMG_LIMIT    = 8'h04;
    localparam logic [7:0] REG_STATUS       = 8'h08;
    localparam logic [7:0] REG_IMGS_STARTED = 8'h0C;
    localparam logic [7:0] REG_IMGS_DONE    = 8'h10;
    localparam logic [7:0] REG_STALL_CYC    = 8'h14;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_CLR_BIT       = 1;
    localparam int STS_DONE_BIT       = 2;
    localparam int STS_CREDIT_ERR_BIT = 3;
    localparam int STS_RESULT_ERR_BIT = 4;

    localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/cl_sde_img_sched_if.sv
// 32-bit cfg register bus; the host drives strobes, the scheduler answers with a
// one-cycle ack one clock later. No backpressure: the host never issues back-to-back strobes.
interface cl_sde_img_sched_if;
    logic [7:0]  cfg_addr;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [31:0] cfg_wdata;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;

    modport master (output cfg_addr, cfg_wr, cfg_rd, cfg_wdata, input cfg_ack, cfg_rdata);
    modport slave  (input cfg_addr, cfg_wr, cfg_rd, cfg_wdata, output cfg_ack, cfg_rdata);
endinterface

// File: rtl/cl_sde_sched_csr.sv
// Scheduler CSR block: decode, ack/rdata, sticky status bits, 32-bit event counters; 1-cycle ack.
// Never stalls the bus; writes land at the ack cycle, reads return state from the strobe cycle.
module cl_sde_sched_csr
    import cl_sde_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    cl_sde_img_sched_if.slave        cfg,
    input  sched_state_e             state,
    input  logic [7:0]               credits,
    input  logic [7:0]               outstanding,
    input  logic                     img_grant,
    input  logic                     res_valid,
    input  logic                     stall,
    input  logic                     done_set,
    input  logic                     done_clr,
    input  logic                     credit_err_set,
    input  logic                     result_err_set,
    output logic                     enable,
    output logic [31:0]              img_limit,
    output logic [31:0]              imgs_started
);
    logic [31:0] imgs_done;
    logic [31:0] stall_cyc;
    logic        done;
    logic        credit_err;
    logic        result_err;
    logic        wr_ctrl;
    logic        wr_limit;
    logic        wr_status;
    logic        clr_cnt;
    logic [31:0] status;
    logic [31:0] rd_mux;

    assign wr_ctrl   = cfg.cfg_wr && (cfg.cfg_addr == REG_CTRL);
    assign wr_limit  = cfg.cfg_wr && (cfg.cfg_addr == REG_IMG_LIMIT);
    assign wr_status = cfg.cfg_wr && (cfg.cfg_addr == REG_STATUS);
    assign clr_cnt   = wr_ctrl && cfg.cfg_wdata[CTRL_CLR_BIT];

    assign status = {8'h00, outstanding, credits, 3'b000, result_err, credit_err, done, state};

    always_comb begin
        rd_mux = RD_DEFAULT;
        case (cfg.cfg_addr)
            REG_CTRL:         rd_mux = {31'b0, enable};
            REG_IMG_LIMIT:    rd_mux = img_limit;
            REG_STATUS:       rd_mux = status;
            REG_IMGS_STARTED: rd_mux = imgs_started;
            REG_IMGS_DONE:    rd_mux = imgs_done;
            REG_STALL_CYC:    rd_mux = stall_cyc;
            default:          rd_mux = RD_DEFAULT;
        endcase
    end

    // Sticky bits: a hardware set in the same cycle as a software clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg.cfg_ack   <= 1'b0;
            cfg.cfg_rdata <= 32'h0;
            enable        <= 1'b0;
            img_limit     <= 32'h0;
            done          <= 1'b0;
            credit_err    <= 1'b0;
            result_err    <= 1'b0;
            imgs_started  <= 32'h0;
            imgs_done     <= 32'h0;
            stall_cyc     <= 32'h0;
        end else begin
            cfg.cfg_ack <= cfg.cfg_wr | cfg.cfg_rd;
            if (cfg.cfg_rd) cfg.cfg_rdata <= rd_mux;
            if (wr_ctrl)    enable        <= cfg.cfg_wdata[CTRL_EN_BIT];
            if (wr_limit)   img_limit     <= cfg.cfg_wdata;

            done       <= done_set | (done & ~done_clr &
                          ~(wr_status & cfg.cfg_wdata[STS_DONE_BIT]));
            credit_err <= credit_err_set | (credit_err &
                          ~(wr_status & cfg.cfg_wdata[STS_CREDIT_ERR_BIT]));
            result_err <= result_err_set | (result_err &
                          ~(wr_status & cfg.cfg_wdata[STS_RESULT_ERR_BIT]));

            if (clr_cnt) begin
                imgs_started <= 32'h0;
                imgs_done    <= 32'h0;
                stall_cyc    <= 32'h0;
            end else begin
                if (img_grant) imgs_started <= imgs_started + 32'd1;
                if (res_valid) imgs_done    <= imgs_done + 32'd1;
                if (stall)     stall_cyc    <= stall_cyc + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cl_sde_img_sched.sv
// Frame scheduler: grants a whole image once buffered and an output slot is free; grant->stream 1 cycle.
// Input side stalls on !inp_valid without truncating; output side is credit-limited to OUT_CREDITS.
module cl_sde_img_sched
    import cl_sde_sched_pkg::*;
#(
    parameter int BEATS_PER_IMG = 1024,
    parameter int OUT_CREDITS   = 16,
    parameter int LVL_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cl_sde_img_sched_if.slave    cfg,
    input  logic [LVL_W-1:0]     inp_level,
    input  logic                 inp_valid,
    output logic                 inp_rd_en,
    input  logic                 res_valid,
    input  logic                 out_pop,
    output logic                 img_start,
    output logic                 img_last,
    output logic                 busy
);
    localparam int              BCW       = (BEATS_PER_IMG > 1) ? $clog2(BEATS_PER_IMG) : 1;
    localparam logic [BCW-1:0]  BEAT_LAST = BCW'(BEATS_PER_IMG - 1);
    localparam logic [7:0]      CRED_MAX  = 8'(OUT_CREDITS);
    localparam logic [31:0]     IMG_BEATS = 32'(BEATS_PER_IMG);

    sched_state_e   state_q, state_d;
    logic [BCW-1:0] beat_cnt_q;
    logic [7:0]     credits_q;
    logic [7:0]     outstanding_q;
    logic           enable;
    logic [31:0]    img_limit;
    logic [31:0]    imgs_started;
    logic           grant;
    logic           beat;
    logic           beat_last;
    logic           level_ok;
    logic           limit_hit;
    logic           done_set;
    logic           done_clr;
    logic           pop_ok;
    logic           res_ok;

    assign inp_rd_en = (state_q == ST_STREAM);
    assign busy      = (state_q != ST_IDLE);
    assign beat      = inp_rd_en & inp_valid;
    assign beat_last = beat && (beat_cnt_q == '0);
    assign level_ok  = 32'(inp_level) >= IMG_BEATS;
    assign limit_hit = (img_limit != 32'h0) && (imgs_started >= img_limit);

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        done_set = 1'b0;
        done_clr = 1'b0;
        case (state_q)
            ST_IDLE: if (enable) begin
                state_d  = ST_WAIT;
                done_clr = 1'b1;
            end
            ST_WAIT: begin
                if (!enable || limit_hit) begin
                    state_d = ST_DRAIN;
                end else if (level_ok && (credits_q != 8'd0)) begin
                    state_d = ST_STREAM;
                    grant   = 1'b1;
                end
            end
            ST_STREAM: if (beat_last) state_d = ST_WAIT;
            ST_DRAIN: if (outstanding_q == 8'd0) begin
                state_d  = ST_IDLE;
                done_set = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pop or result that finds its counter at the limit is an error unless a
    // grant in the same cycle makes room for it.
    assign pop_ok = out_pop & ((credits_q != CRED_MAX) | grant);
    assign res_ok = res_valid & ((outstanding_q != 8'd0) | grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            credits_q     <= CRED_MAX;
            outstanding_q <= 8'd0;
            img_start     <= 1'b0;
            img_last      <= 1'b0;
        end else begin
            state_q   <= state_d;
            img_start <= grant;
            img_last  <= beat_last;
            if (grant)     beat_cnt_q <= BEAT_LAST;
            else if (beat) beat_cnt_q <= beat_cnt_q - 1'b1;
            credits_q     <= credits_q - {7'b0, grant} + {7'b0, pop_ok};
            outstanding_q <= outstanding_q + {7'b0, grant} - {7'b0, res_ok};
        end
    end

    cl_sde_sched_csr u_csr (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg            (cfg),
        .state          (state_q),
        .credits        (credits_q),
        .outstanding    (outstanding_q),
        .img_grant      (grant),
        .res_valid      (res_valid),
        .stall          (inp_rd_en & ~inp_valid),
        .done_set       (done_set),
        .done_clr       (done_clr),
        .credit_err_set (out_pop & ~pop_ok),
        .result_err_set (res_valid & ~res_ok),
        .enable         (enable),
        .img_limit      (img_limit),
        .imgs_started   (imgs_started)
    );

endmodule

// File: tb/tb_cl_sde_img_sched.sv
// Self-checking bench for cl_sde_img_sched with 4-beat images and 2 output credits.
// CSR reads are scoreboarded: expected value queued at the strobe, compared at the ack.
`timescale 1ns/1ps
module tb_cl_sde_img_sched;
    import cl_sde_sched_pkg::*;

    localparam int BEATS = 4;
    localparam int CREDS = 2;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cl_sde_img_sched_if cfg();

    logic [LW-1:0] inp_level;
    logic inp_valid, inp_rd_en, res_valid, out_pop, img_start, img_last, busy;
    logic res_man, pop_man, auto_resp;
    logic res_auto = 1'b0;
    logic pop_auto = 1'b0;

    assign res_valid = res_man | res_auto;
    assign out_pop   = pop_man | pop_auto;

    cl_sde_img_sched #(.BEATS_PER_IMG(BEATS), .OUT_CREDITS(CREDS), .LVL_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg.slave),
        .inp_level (inp_level),
        .inp_valid (inp_valid),
        .inp_rd_en (inp_rd_en),
        .res_valid (res_valid),
        .out_pop   (out_pop),
        .img_start (img_start),
        .img_last  (img_last),
        .busy      (busy)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc_rd_en = 0;
    int n_start   = 0;
    int n_last    = 0;
    int s_rd, s_st, s_la;

    always @(negedge clk) begin
        if (inp_rd_en === 1'b1) cyc_rd_en++;
        if (img_start === 1'b1) n_start++;
        if (img_last === 1'b1)  n_last++;
    end

    // Result/pop responder standing in for the engine and output consumer.
    always @(negedge clk) begin
        res_auto = auto_resp && (img_last === 1'b1);
        pop_auto = auto_resp && (img_last === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string tag);
        bit   got = 0;
        exp_t e;
        for (int i = 0; i < 4 && !got; i++) begin
            if (cfg.cfg_ack === 1'b1) got = 1;
            else @(negedge clk);
        end
        if (sb.size() > 0) e = sb.pop_front();
        if (!got) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
        else if (e.is_rd) check(e.tag, cfg.cfg_rdata, e.val);
    endtask

    task automatic cfg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        cfg.cfg_addr = addr;
        cfg.cfg_rd   = 1'b1;
        sb.push_back('{1'b1, exp, tag});
        @(negedge clk);
        cfg.cfg_rd = 1'b0;
        wait_ack(tag);
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        cfg.cfg_addr  = addr;
        cfg.cfg_wdata = data;
        cfg.cfg_wr    = 1'b1;
        sb.push_back('{1'b0, 32'h0, "wr"});
        @(negedge clk);
        cfg.cfg_wr = 1'b0;
        wait_ack("wr");
    endtask

    task automatic pulse(input logic r, input logic p);
        res_man = r;
        pop_man = p;
        @(negedge clk);
        res_man = 1'b0;
        pop_man = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (img_start === 1'b1) seen = 1;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_busy, found;
        cfg.cfg_addr = 8'h0; cfg.cfg_wr = 1'b0; cfg.cfg_rd = 1'b0; cfg.cfg_wdata = 32'h0;
        inp_level = '0; inp_valid = 1'b1; res_man = 1'b0; pop_man = 1'b0; auto_resp = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rd_en",  32'(inp_rd_en), 32'd0);
        check("rst_start",  32'(img_start), 32'd0);
        check("rst_last",   32'(img_last),  32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_ack",    32'(cfg.cfg_ack), 32'd0);
        check("rst_rdata",  cfg.cfg_rdata,  32'd0);
        rst_n = 1'b1;
        idle(1);
        cfg_read(REG_STATUS, 32'h0000_0200, "rst_status");
        cfg_read(REG_IMGS_STARTED, 32'd0, "rst_started");

        // Level 3 must not grant; level 4 grants on the next cycle.
        inp_level = 16'd3;
        s_rd = cyc_rd_en;
        cfg_write(REG_CTRL, 32'h1);
        idle(4);
        check("lvl3_no_rd", 32'(cyc_rd_en - s_rd), 32'd0);
        check("lvl3_busy", 32'(busy), 32'd1);
        cfg_read(REG_STATUS, 32'h0000_0201, "lvl3_status");
        s_rd = cyc_rd_en; s_st = n_start; s_la = n_last;
        inp_level = 16'd4;
        @(negedge clk);
        check("start_lat", 32'(img_start), 32'd1);
        check("rd_en_lat", 32'(inp_rd_en), 32'd1);
        inp_level = 16'd0;
        idle(8);
        check("img1_beats", 32'(cyc_rd_en - s_rd), 32'd4);
        check("img1_last",  32'(n_last - s_la),    32'd1);
        check("img1_start", 32'(n_start - s_st),   32'd1);
        cfg_read(REG_IMGS_STARTED, 32'd1, "img1_started");
        cfg_read(REG_STATUS, 32'h0001_0101, "img1_status");
        pulse(1'b1, 1'b1);
        cfg_read(REG_STATUS, 32'h0000_0201, "img1_ret_status");
        cfg_read(REG_IMGS_DONE, 32'd1, "img1_done_cnt");

        // Credit exhaustion: two grants, stall, one pop frees a third.
        s_st = n_start;
        inp_level = 16'd100;
        idle(20);
        check("cred_two_grants", 32'(n_start - s_st), 32'd2);
        cfg_read(REG_STATUS, 32'h0002_0001, "cred_zero_status");
        pulse(1'b0, 1'b1);
        idle(10);
        check("cred_third_grant", 32'(n_start - s_st), 32'd3);
        inp_level = 16'd0;
        cfg_read(REG_STATUS, 32'h0003_0001, "cred_third_status");
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        cfg_read(REG_STATUS, 32'h0000_0201, "cred_ret_status");
        cfg_read(REG_IMGS_STARTED, 32'd4, "cred_started");
        cfg_write(REG_CTRL, 32'h3);
        cfg_read(REG_IMGS_STARTED, 32'd0, "clr_started");
        cfg_read(REG_IMGS_DONE, 32'd0, "clr_done_cnt");
        cfg_read(REG_CTRL, 32'h1, "ctrl_selfclr");

        // Alternating inp_valid: 4 beats over 8 cycles, 4 stall cycles.
        s_rd = cyc_rd_en; s_la = n_last;
        inp_level = 16'd4;
        wait_start("stall_start_timeout");
        inp_level = 16'd0;
        for (int i = 0; i < 8; i++) begin
            inp_valid = (i % 2 == 1);
            @(negedge clk);
        end
        inp_valid = 1'b1;
        idle(2);
        check("stall_rd_cycles", 32'(cyc_rd_en - s_rd), 32'd8);
        check("stall_last", 32'(n_last - s_la), 32'd1);
        cfg_read(REG_STALL_CYC, 32'd4, "stall_cnt");
        pulse(1'b1, 1'b1);

        // Disable on the second beat: image completes, then DRAIN until the result.
        s_rd = cyc_rd_en; s_la = n_last;
        inp_level = 16'd4;
        wait_start("drain_start_timeout");
        inp_level = 16'd0;
        @(negedge clk);
        cfg_write(REG_CTRL, 32'h0);
        idle(6);
        check("drain_beats", 32'(cyc_rd_en - s_rd), 32'd4);
        check("drain_last",  32'(n_last - s_la),    32'd1);
        cfg_read(REG_STATUS, 32'h0001_0103, "drain_status");
        pulse(1'b1, 1'b0);
        idle(2);
        cfg_read(REG_STATUS, 32'h0000_0104, "drain_done_status");
        check("drain_idle_busy", 32'(busy), 32'd0);
        pulse(1'b0, 1'b1);

        // IMG_LIMIT=3 with continuous supply and an automatic responder.
        cfg_write(REG_CTRL, 32'h2);
        cfg_write(REG_IMG_LIMIT, 32'd3);
        s_st = n_start;
        auto_resp = 1'b1;
        inp_level = 16'd100;
        cfg_write(REG_CTRL, 32'h1);
        seen_busy = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (busy === 1'b1) seen_busy = 1;
            else if (seen_busy) found = 1;
            if (!found) @(negedge clk);
        end
        check("limit_idle_seen", 32'(found), 32'd1);
        cfg_write(REG_CTRL, 32'h0);
        auto_resp = 1'b0;
        inp_level = 16'd0;
        idle(4);
        check("limit_starts", 32'(n_start - s_st), 32'd3);
        cfg_read(REG_IMGS_STARTED, 32'd3, "limit_started");
        cfg_read(REG_IMGS_DONE, 32'd3, "limit_done_cnt");
        cfg_read(REG_STATUS, 32'h0000_0204, "limit_status");

        // Error stickies, their clear, and unmapped offsets.
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        cfg_read(REG_STATUS, 32'h0000_021C, "err_status");
        cfg_write(REG_STATUS, 32'h18);
        cfg_read(REG_STATUS, 32'h0000_0204, "err_clr_status");
        cfg_write(8'h20, 32'h55);
        cfg_read(8'h20, 32'hDEADBEEF, "unmapped_rd");
        cfg_read(REG_IMG_LIMIT, 32'd3, "limit_readback");

        // Asynchronous reset in the middle of an image.
        cfg_write(REG_IMG_LIMIT, 32'd0);
        cfg_write(REG_CTRL, 32'h1);
        inp_level = 16'd4;
        wait_start("rst_start_timeout");
        inp_level = 16'd0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd_en", 32'(inp_rd_en), 32'd0);
        check("async_rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        cfg_read(REG_STATUS, 32'h0000_0200, "post_rst_status");
        cfg_read(REG_IMGS_STARTED, 32'd0, "post_rst_started");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cl_sde_img_sched.md
# cl_sde_img_sched

Frame-level scheduler for the SDE streaming classifier path. It sits between the input pixel FIFO, the classifier engine and the output result FIFO. It releases one whole image (BEATS_PER_IMG beats) to the engine only when the image is fully buffered and an output-FIFO slot is reserved. It tracks outstanding results and exposes control, status and counters on the 32-bit cfg register bus.

## Interface
- BEATS_PER_IMG, 1024: 64-bit pixel beats per image; must be ≥1.
- OUT_CREDITS, 16: output FIFO depth, in results.
- LVL_W, 16: width of input FIFO occupancy.
- clk  in  1  single clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- cfg_addr  in  8  register byte offset.
- cfg_wr  in  1  write strobe.
- cfg_rd  in  1  read strobe.
- cfg_wdata  in  32  write data.
- cfg_ack  out  1  one-cycle ack pulse.
- cfg_rdata  out  32  read data, valid with cfg_ack.
- inp_level  in  LVL_W  input FIFO occupancy, in beats.
- inp_valid  in  1  input FIFO dout valid (first-word fall-through).
- inp_rd_en  out  1  pop/forward enable to input FIFO and engine.
- res_valid  in  1  engine wrote one result into the output FIFO.
- out_pop  in  1  output FIFO popped (ots_valid & ots_ready).
- img_start  out  1  pulse on the cycle an image is granted.
- img_last  out  1  pulse on the final beat consumed for an image.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - 0x00 CTRL (RW): [0] enable, [1] clear counters (self-clearing).
  - 0x04 IMG_LIMIT (RW): 0 = unlimited.
  - 0x08 STATUS (RO): [1:0] state, [2] done (sticky), [3] credit_err (sticky), [4] result_err (sticky), [15:8] credits, [23:16] outstanding.
  - 0x0C IMGS_STARTED (RO).
  - 0x10 IMGS_DONE (RO): res_valid count.
  - 0x14 STALL_CYC (RO).
  - Other offsets read 0xDEADBEEF and ignore writes.
  - Writing STATUS with data bit n set clears sticky bit n.
- Beat consumed = inp_rd_en & inp_valid.
- FSM, encoded IDLE=0, WAIT=1, STREAM=2, DRAIN=3:
  - IDLE: enable=1 → WAIT. Clears done on entry to WAIT.
  - WAIT:
    - If enable=0 → DRAIN.
    - Else if IMG_LIMIT≠0 and IMGS_STARTED≥IMG_LIMIT → DRAIN.
    - Else if inp_level≥BEATS_PER_IMG and credits>0 → STREAM. Pulse img_start, load beat_cnt=BEATS_PER_IMG-1, credits−1, outstanding+1, IMGS_STARTED+1.
  - STREAM:
    - inp_rd_en=1. Each consumed beat decrements beat_cnt.
    - Consumed beat with beat_cnt==0 → pulse img_last, go to WAIT.
    - Clearing enable mid-image never truncates; the image completes first.
    - inp_rd_en & !inp_valid increments STALL_CYC.
  - DRAIN: outstanding==0 → IDLE, set done.
- Credits:
  - Reset to OUT_CREDITS.
  - +1 on out_pop, −1 on grant. Grant and out_pop in the same cycle net zero.
  - out_pop with credits==OUT_CREDITS (and no grant) is ignored and sets credit_err.
- Outstanding:
  - +1 on grant, −1 on res_valid. Both in the same cycle net zero.
  - res_valid with outstanding==0 is ignored and sets result_err.
- Counters:
  - 32-bit, wrap modulo 2^32.
  - Cleared by CTRL[1]. Clearing does not affect FSM, credits or outstanding.
- Reset values:
  - cfg_ack=0, cfg_rdata=0, inp_rd_en=0, img_start=0, img_last=0, busy=0.
  - State IDLE, credits=OUT_CREDITS, everything else 0.
- Reset mid-STREAM aborts immediately. The system resets the FIFOs together with this block.

## Timing
- Grant condition true at cycle N → state STREAM and inp_rd_en=1 at N+1. img_start is registered and high at N+1.
- inp_rd_en and busy are decoded from registered state, with no combinational path from inputs.
- With inp_valid constantly 1, an image occupies exactly BEATS_PER_IMG cycles of inp_rd_en. The next grant is at the earliest one WAIT cycle later, so the minimum period is BEATS_PER_IMG+1 cycles.
- img_last is registered and high the cycle after the final consumed beat.
- cfg_ack: strobe at cycle N → ack at N+1. Register writes take effect at N+1. Read data reflects state at N.
- Strobes arriving while ack is high are accepted; the bus never issues back-to-back strobes.

## Structure
- Package cl_sde_sched_pkg holds:
  - the state enum;
  - register offset localparams;
  - STATUS bit positions;
  - the 0xDEADBEEF default read value.
- Sub-module cl_sde_sched_csr holds:
  - register decode, ack and rdata;
  - sticky bits;
  - the three 32-bit counters.
- The top level holds the FSM, beat counter, credit and outstanding tracking.

## Test plan
- BEATS_PER_IMG=4, enable=1, inp_level stepping 3→4:
  - no inp_rd_en at level 3;
  - img_start one cycle after level=4;
  - exactly 4 cycles of inp_rd_en, img_last once;
  - IMGS_STARTED=1.
- OUT_CREDITS=2, no out_pop, ample input:
  - exactly 2 images granted, then WAIT with credits=0;
  - one out_pop → a third grant follows.
- inp_valid toggling 1/0 during STREAM: 4 beats span 8 cycles, STALL_CYC=4.
- Clear enable at the 2nd beat of an image:
  - image completes, then DRAIN;
  - IDLE with done=1 after res_valid arrives.
- IMG_LIMIT=3 with continuous supply:
  - IMGS_STARTED stops at 3;
  - IDLE after 3 res_valid pulses, done=1.
- Error and reset cases:
  - res_valid with outstanding 0 sets result_err;
  - out_pop at full credits sets credit_err;
  - writing STATUS=0x18 clears both;
  - rst_n low mid-STREAM forces inp_rd_en=0 with no clock edge required.
